// File: rtl/rps_referee_pkg.sv
// Shared encodings for the rock-paper-scissors referee: moves, outcomes and FSM states.
// Also holds the single-round rule function used by the referee.
package rps_referee_pkg;

    localparam logic [1:0] ROCK     = 2'b00;
    localparam logic [1:0] SCISSORS = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] ILLEGAL  = 2'b11;

    localparam logic [1:0] DRAW     = 2'b00;
    localparam logic [1:0] USER_WIN = 2'b01;
    localparam logic [1:0] CPU_WIN  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_CPU = 2'b01,
        SCORE    = 2'b10,
        DONE     = 2'b11
    } state_t;

    // Both moves are assumed legal; illegal moves are filtered before scoring.
    function automatic logic [1:0] round_outcome(input logic [1:0] user, input logic [1:0] cpu);
        logic [1:0] outcome;
        outcome = CPU_WIN;
        if (user == cpu) begin
            outcome = DRAW;
        end else if ((user == ROCK     && cpu == SCISSORS) ||
                     (user == SCISSORS && cpu == PAPER)    ||
                     (user == PAPER    && cpu == ROCK)) begin
            outcome = USER_WIN;
        end
        return outcome;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low 7-segment pattern, segment order g..a.
module seg7_decoder (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/rps_referee.sv
// Referee for a user-versus-predictor rock-paper-scissors match.
// Round results are registered on the cpu_valid edge so they are visible during the SCORE cycle.
module rps_referee
    import rps_referee_pkg::*;
#(
    parameter int WIN_TARGET = 5,
    parameter int MAX_ROUNDS = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_match,
    input  logic       round_valid,
    input  logic [1:0] user_move,
    input  logic       cpu_valid,
    input  logic [1:0] cpu_move,
    output logic       result_valid,
    output logic [1:0] result,
    output logic       update,
    output logic [1:0] learn_move,
    output logic       move_err,
    output logic [3:0] user_score,
    output logic [3:0] cpu_score,
    output logic [5:0] round_count,
    output logic       match_over,
    output logic [1:0] winner,
    output logic [6:0] hex_user,
    output logic [6:0] hex_cpu
);

    localparam logic [3:0] WIN_T = 4'(WIN_TARGET);
    localparam logic [5:0] MAX_R = 6'(MAX_ROUNDS);

    state_t     state;
    state_t     state_next;
    logic [1:0] user_q;
    logic [1:0] outcome;
    logic       match_end;

    assign outcome   = round_outcome(user_q, cpu_move);
    assign match_end = (user_score == WIN_T) || (cpu_score == WIN_T) || (round_count == MAX_R);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (round_valid && user_move != ILLEGAL) state_next = WAIT_CPU;
            WAIT_CPU: if (cpu_valid) state_next = SCORE;
            SCORE:    state_next = match_end ? DONE : IDLE;
            DONE:     state_next = DONE;
            default:  state_next = IDLE;
        endcase
        if (new_match) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            user_q       <= ROCK;
            result_valid <= 1'b0;
            update       <= 1'b0;
            move_err     <= 1'b0;
            result       <= DRAW;
            learn_move   <= ROCK;
            user_score   <= 4'd0;
            cpu_score    <= 4'd0;
            round_count  <= 6'd0;
        end else begin
            result_valid <= 1'b0;
            update       <= 1'b0;
            move_err     <= 1'b0;
            if (new_match) begin
                user_score  <= 4'd0;
                cpu_score   <= 4'd0;
                round_count <= 6'd0;
            end else if (state == IDLE && round_valid) begin
                if (user_move == ILLEGAL) begin
                    move_err <= 1'b1;
                end else begin
                    user_q <= user_move;
                end
            end else if (state == WAIT_CPU && cpu_valid) begin
                if (cpu_move == ILLEGAL) begin
                    move_err <= 1'b1;
                end else begin
                    result_valid <= 1'b1;
                    update       <= 1'b1;
                    result       <= outcome;
                    learn_move   <= user_q;
                    // Counters saturate independently of the match-end parameters.
                    if (outcome == USER_WIN && user_score != 4'hF) begin
                        user_score <= user_score + 4'd1;
                    end
                    if (outcome == CPU_WIN && cpu_score != 4'hF) begin
                        cpu_score <= cpu_score + 4'd1;
                    end
                    if (round_count != 6'h3F) begin
                        round_count <= round_count + 6'd1;
                    end
                end
            end
        end
    end

    assign match_over = (state == DONE);

    always_comb begin
        winner = DRAW;
        if (state == DONE) begin
            if (user_score == WIN_T) begin
                winner = USER_WIN;
            end else if (cpu_score == WIN_T) begin
                winner = CPU_WIN;
            end else if (user_score > cpu_score) begin
                winner = USER_WIN;
            end else if (cpu_score > user_score) begin
                winner = CPU_WIN;
            end
        end
    end

    seg7_decoder u_hex_user (.value(user_score), .seg(hex_user));
    seg7_decoder u_hex_cpu  (.value(cpu_score),  .seg(hex_cpu));

endmodule

// File: tb/tb_rps_referee.sv
// Bench for rps_referee: two instances (default limits and MAX_ROUNDS=4) share stimulus
// and are compared each cycle against a per-instance match model.
module tb_rps_referee;

    logic       clock = 1'b0;
    logic       reset, new_match, round_valid, cpu_valid;
    logic [1:0] user_move, cpu_move;

    logic       rv[2], upd[2], err[2], mo[2];
    logic [1:0] res[2], learn[2], win[2];
    logic [3:0] us[2], cs[2];
    logic [5:0] rc[2];
    logic [6:0] hu[2], hc[2];

    always #5 clock = ~clock;

    rps_referee #(.WIN_TARGET(5), .MAX_ROUNDS(60)) dut (
        .clock(clock), .reset(reset), .new_match(new_match),
        .round_valid(round_valid), .user_move(user_move),
        .cpu_valid(cpu_valid), .cpu_move(cpu_move),
        .result_valid(rv[0]), .result(res[0]), .update(upd[0]), .learn_move(learn[0]),
        .move_err(err[0]), .user_score(us[0]), .cpu_score(cs[0]), .round_count(rc[0]),
        .match_over(mo[0]), .winner(win[0]), .hex_user(hu[0]), .hex_cpu(hc[0])
    );

    rps_referee #(.WIN_TARGET(5), .MAX_ROUNDS(4)) dut_short (
        .clock(clock), .reset(reset), .new_match(new_match),
        .round_valid(round_valid), .user_move(user_move),
        .cpu_valid(cpu_valid), .cpu_move(cpu_move),
        .result_valid(rv[1]), .result(res[1]), .update(upd[1]), .learn_move(learn[1]),
        .move_err(err[1]), .user_score(us[1]), .cpu_score(cs[1]), .round_count(rc[1]),
        .match_over(mo[1]), .winner(win[1]), .hex_user(hu[1]), .hex_cpu(hc[1])
    );

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: phase 0 waiting for user, 1 waiting for cpu, 2 round just scored, 3 match finished.
    int m_us[2], m_cs[2], m_rc[2], m_phase[2], m_user[2], m_res[2], m_learn[2];
    bit m_rv[2], m_err[2];
    int n_pass  = 0;
    int n_total = 0;

    function automatic int max_rounds_of(input int i);
        return (i == 0) ? 60 : 4;
    endfunction

    function automatic int model_winner(input int i);
        if (m_phase[i] != 3) return 0;
        if (m_us[i] == 5) return 1;
        if (m_cs[i] == 5) return 2;
        if (m_us[i] > m_cs[i]) return 1;
        if (m_cs[i] > m_us[i]) return 2;
        return 0;
    endfunction

    task automatic model_update(input int i);
        int d;
        m_rv[i]  = 1'b0;
        m_err[i] = 1'b0;
        if (reset) begin
            m_us[i] = 0; m_cs[i] = 0; m_rc[i] = 0; m_phase[i] = 0;
            m_res[i] = 0; m_learn[i] = 0; m_user[i] = 0;
        end else if (new_match) begin
            m_us[i] = 0; m_cs[i] = 0; m_rc[i] = 0; m_phase[i] = 0;
        end else begin
            case (m_phase[i])
                0: if (round_valid) begin
                    if (user_move == 2'd3) m_err[i] = 1'b1;
                    else begin
                        m_user[i]  = int'(user_move);
                        m_phase[i] = 1;
                    end
                end
                1: if (cpu_valid) begin
                    if (cpu_move == 2'd3) m_err[i] = 1'b1;
                    else begin
                        // rock=0, scissors=1, paper=2: each move beats the one after it (mod 3).
                        d = (int'(cpu_move) - m_user[i] + 3) % 3;
                        m_res[i]   = (d == 0) ? 0 : ((d == 1) ? 1 : 2);
                        m_rv[i]    = 1'b1;
                        m_learn[i] = m_user[i];
                        if (d == 1 && m_us[i] < 15) m_us[i]++;
                        if (d == 2 && m_cs[i] < 15) m_cs[i]++;
                        if (m_rc[i] < 63) m_rc[i]++;
                    end
                    m_phase[i] = 2;
                end
                2: m_phase[i] = (m_us[i] == 5 || m_cs[i] == 5 || m_rc[i] == max_rounds_of(i)) ? 3 : 0;
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check("result_valid", i, 8'(rv[i]),    8'(m_rv[i]));
            check("update",       i, 8'(upd[i]),   8'(m_rv[i]));
            check("result",       i, 8'(res[i]),   8'(m_res[i]));
            check("learn_move",   i, 8'(learn[i]), 8'(m_learn[i]));
            check("move_err",     i, 8'(err[i]),   8'(m_err[i]));
            check("user_score",   i, 8'(us[i]),    8'(m_us[i]));
            check("cpu_score",    i, 8'(cs[i]),    8'(m_cs[i]));
            check("round_count",  i, 8'(rc[i]),    8'(m_rc[i]));
            check("match_over",   i, 8'(mo[i]),    8'(m_phase[i] == 3));
            check("winner",       i, 8'(win[i]),   8'(model_winner(i)));
            check("hex_user",     i, 8'(hu[i]),    8'(seg_tab[m_us[i]]));
            check("hex_cpu",      i, 8'(hc[i]),    8'(seg_tab[m_cs[i]]));
        end
    endtask

    task automatic step(input bit rst, input bit nm, input bit rvl, input logic [1:0] um,
                        input bit cvl, input logic [1:0] cm);
        reset = rst; new_match = nm; round_valid = rvl; user_move = um;
        cpu_valid = cvl; cpu_move = cm;
        @(posedge clock);
        model_update(0);
        model_update(1);
        #1;
        check_all();
        reset = 1'b0; new_match = 1'b0; round_valid = 1'b0; cpu_valid = 1'b0;
    endtask

    task automatic play(input logic [1:0] um, input logic [1:0] cm);
        step(0, 0, 1, um, 0, 2'd0);
        step(0, 0, 0, 2'd0, 1, cm);
        step(0, 0, 0, 2'd0, 0, 2'd0);
    endtask

    initial begin
        reset = 1'b1; new_match = 1'b0; round_valid = 1'b0; cpu_valid = 1'b0;
        user_move = 2'd0; cpu_move = 2'd0;
        #1;
        step(1, 0, 0, 2'd0, 0, 2'd0);
        step(1, 0, 0, 2'd0, 0, 2'd0);
        check("lit_reset_hex", 0, 8'(hu[0]), 8'h40);

        // rock beats scissors
        step(0, 0, 1, 2'd0, 0, 2'd0);
        step(0, 0, 0, 2'd0, 1, 2'd1);
        check("lit_rv_latency", 0, 8'(rv[0]), 8'h1);
        check("lit_result_win", 0, 8'(res[0]), 8'h1);
        check("lit_user_score", 0, 8'(us[0]), 8'h1);
        check("lit_round_cnt",  0, 8'(rc[0]), 8'h1);
        check("lit_learn",      0, 8'(learn[0]), 8'h0);
        step(0, 0, 0, 2'd0, 0, 2'd0);

        play(2'd2, 2'd1);
        check("lit_cpu_score", 0, 8'(cs[0]), 8'h1);
        play(2'd2, 2'd2);
        check("lit_draw_rc", 0, 8'(rc[0]), 8'h3);

        // illegal user, then illegal cpu
        step(0, 0, 1, 2'd3, 0, 2'd0);
        check("lit_user_err", 0, 8'(err[0]), 8'h1);
        step(0, 0, 0, 2'd0, 0, 2'd0);
        step(0, 0, 1, 2'd0, 0, 2'd0);
        step(0, 0, 1, 2'd1, 1, 2'd3);
        check("lit_cpu_err", 0, 8'(err[0]), 8'h1);
        check("lit_cpu_err_rc", 0, 8'(rc[0]), 8'h3);
        step(0, 0, 0, 2'd0, 0, 2'd0);

        // round limit with draws only
        step(0, 1, 0, 2'd0, 0, 2'd0);
        for (int k = 0; k < 4; k++) play(2'(k % 3), 2'(k % 3));
        check("lit_short_over", 1, 8'(mo[1]), 8'h1);
        check("lit_short_win",  1, 8'(win[1]), 8'h0);

        // five user wins, then ignored rounds, then new_match
        step(0, 1, 0, 2'd0, 0, 2'd0);
        for (int k = 0; k < 5; k++) play(2'd2, 2'd0);
        check("lit_main_over", 0, 8'(mo[0]), 8'h1);
        check("lit_main_win",  0, 8'(win[0]), 8'h1);
        check("lit_hex_five",  0, 8'(hu[0]), 8'h12);
        step(0, 0, 1, 2'd0, 1, 2'd1);
        step(0, 0, 1, 2'd0, 1, 2'd1);
        check("lit_done_ignored", 0, 8'(us[0]), 8'h5);
        step(0, 1, 1, 2'd0, 1, 2'd1);
        check("lit_new_match_over", 0, 8'(mo[0]), 8'h0);
        check("lit_new_match_rc",   0, 8'(rc[0]), 8'h0);

        // reset while waiting for the cpu move
        step(0, 0, 1, 2'd0, 0, 2'd0);
        step(1, 0, 0, 2'd0, 0, 2'd0);
        step(0, 0, 0, 2'd0, 1, 2'd1);
        check("lit_reset_mid_rv", 0, 8'(rv[0]), 8'h0);
        check("lit_reset_mid_us", 0, 8'(us[0]), 8'h0);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rps_referee.md
RPS_REFEREE -- requirements
Module: rps_referee

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
- WIN_TARGET, 5, wins needed to end a match.
- MAX_ROUNDS, 60, round limit per match.
REQ-002 Ports, one per line (name  direction  width  meaning) SHALL be:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- new_match  in  1  one-cycle pulse; clears the match.
- round_valid  in  1  one-cycle pulse; user_move is committed.
- user_move  in  2  user move.
- cpu_valid  in  1  one-cycle pulse; cpu_move from the predictor is valid.
- cpu_move  in  2  machine move.
- result_valid  out  1  one-cycle pulse; result is valid.
- result  out  2  round outcome.
- update  out  1  one-cycle pulse to the predictor carrying learn_move.
- learn_move  out  2  user move of the scored round.
- move_err  out  1  one-cycle pulse; an illegal move was rejected.
- user_score  out  4  user wins.
- cpu_score  out  4  machine wins.
- round_count  out  6  rounds scored.
- match_over  out  1  match has ended.
- winner  out  2  final winner.
- hex_user  out  7  active-low 7-segment display of user_score.
- hex_cpu  out  7  active-low 7-segment display of cpu_score.
REQ-003 Move encoding SHALL be: 00 rock, 01 scissors, 10 paper, 11 illegal.
REQ-004 result and winner encoding SHALL be: 00 draw, 01 user wins, 10 cpu wins, 11 unused.

Function
REQ-005 FSM states SHALL be IDLE, WAIT_CPU, SCORE and DONE.
REQ-006 IDLE transitions SHALL be:
- round_valid with a legal user_move: latch the move, go to WAIT_CPU.
- round_valid with user_move = 11: pulse move_err next cycle, stay IDLE.
REQ-007 In WAIT_CPU, cpu_valid SHALL latch cpu_move and go to SCORE; round_valid SHALL be ignored.
REQ-008 If cpu_move = 11, SCORE SHALL pulse move_err, leave scores and round_count unchanged, and return to IDLE.
REQ-009 On a legal SCORE cycle, the block SHALL assert result_valid and update, drive result, set learn_move to the latched user move, and update scores and round_count.
- Latency: cpu_valid at edge t gives result_valid high during the cycle after t.
REQ-010 Rules SHALL be:
- rock beats scissors, scissors beats paper, paper beats rock.
- Equal moves are a draw.
REQ-011 A win SHALL add 1 to the winning score; a draw SHALL change no score; every legal round SHALL add 1 to round_count.
REQ-012 Match end SHALL be checked in SCORE using the updated values; the FSM goes to DONE if either score = WIN_TARGET or round_count = MAX_ROUNDS, otherwise to IDLE.
REQ-013 In DONE, match_over SHALL be 1 and winner SHALL be:
- the side that reached WIN_TARGET; else
- the higher score; else
- 00 (draw).
REQ-014 In DONE, round_valid and cpu_valid SHALL be ignored.
REQ-015 Scores SHALL saturate at 15 and round_count at 63, regardless of parameters.
REQ-016 new_match in any state SHALL clear scores, round_count, match_over and winner, and go to IDLE; it has priority over round_valid and cpu_valid in the same cycle.
REQ-017 result and learn_move SHALL hold their last value between pulses.
REQ-018 hex_user and hex_cpu SHALL be combinational decodes of the current scores, showing hex digits 0-F, segment order g..a, with 0 lighting a segment.

Reset
REQ-019 reset SHALL return the FSM to IDLE and clear every register:
- pulses, result, learn_move, scores, round_count, match_over and winner all 0.
- hex_user and hex_cpu then show "0" (7'b1000000).
REQ-020 reset SHALL override new_match and all other inputs, including mid-round (WAIT_CPU or SCORE), and SHALL discard any latched moves.

Structure
REQ-021 A shared package SHALL hold:
- move constants ROCK, SCISSORS, PAPER and ILLEGAL.
- outcome constants DRAW, USER_WIN and CPU_WIN.
- the FSM state type.
REQ-022 The 7-segment decode SHALL be a separate sub-module named seg7_decoder, instantiated twice.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- user rock, cpu scissors -> result_valid 1 cycle after cpu_valid, result 01, user_score 1, round_count 1, update with learn_move 00.
- user paper, cpu scissors -> result 10, cpu_score 1; user paper, cpu paper -> result 00, scores unchanged, round_count +1.
- user_move 11 in IDLE -> move_err pulse, no state change; cpu_move 11 -> move_err, round_count unchanged, back to IDLE.
- five user wins with WIN_TARGET = 5 -> match_over 1, winner 01, hex_user 7'b0010010; further round_valid ignored; new_match clears all.
- MAX_ROUNDS = 4 with draws only -> match_over after round 4, winner 00.
- reset asserted in WAIT_CPU, then cpu_valid -> no result_valid, all outputs at reset values.
